// File: rtl/psu_pkg.sv
// Shared PSU definitions: field widths, codeword codes, sequence-select encodings
// and the default INIT/MEAS/RESM programs loaded into the sequence store at reset.
package psu_pkg;

    localparam int PSU_TIME_BW  = 16;
    localparam int PSU_CWD_BW   = 8;
    localparam int PSU_ENTRY_BW = PSU_TIME_BW + 2 * PSU_CWD_BW;

    typedef logic [PSU_ENTRY_BW-1:0] entry_t;

    localparam logic [PSU_CWD_BW-1:0] CWD_IDLE  = 8'h00;
    localparam logic [PSU_CWD_BW-1:0] CWD_X90   = 8'h01;
    localparam logic [PSU_CWD_BW-1:0] CWD_Y90   = 8'h02;
    localparam logic [PSU_CWD_BW-1:0] CWD_X180  = 8'h03;
    localparam logic [PSU_CWD_BW-1:0] CWD_MEAS  = 8'h10;
    localparam logic [PSU_CWD_BW-1:0] CWD_RESET = 8'h20;

    localparam logic [PSU_TIME_BW-1:0] SQGATE     = 16'd4;
    localparam logic [PSU_TIME_BW-1:0] TQGATE     = 16'd8;
    localparam logic [PSU_TIME_BW-1:0] MEAS_CYCLE = 16'd50;

    typedef enum logic [1:0] {
        SELCNT_INIT = 2'd0,
        SELCNT_MEAS = 2'd1,
        SELCNT_RESM = 2'd2,
        SELCNT_USER = 2'd3
    } selcnt_e;

    localparam int INIT_LEN = 3;
    localparam int MEAS_LEN = 2;
    localparam int RESM_LEN = 20;

    localparam entry_t INIT_PROG [INIT_LEN] = '{
        {SQGATE, CWD_X90,  CWD_IDLE},
        {SQGATE, CWD_Y90,  CWD_IDLE},
        {TQGATE, CWD_X180, CWD_IDLE}
    };

    localparam entry_t MEAS_PROG [MEAS_LEN] = '{
        {MEAS_CYCLE, CWD_MEAS, CWD_IDLE},
        {SQGATE,     CWD_IDLE, CWD_RESET}
    };

    // Reset-and-measure train: alternating pi pulses, cwdsp carries the step index.
    localparam entry_t RESM_PROG [RESM_LEN] = '{
        {16'd10,  CWD_X180, 8'd0},  {16'd20,  CWD_IDLE, 8'd1},
        {16'd30,  CWD_X180, 8'd2},  {16'd40,  CWD_IDLE, 8'd3},
        {16'd50,  CWD_X180, 8'd4},  {16'd60,  CWD_IDLE, 8'd5},
        {16'd70,  CWD_X180, 8'd6},  {16'd80,  CWD_IDLE, 8'd7},
        {16'd90,  CWD_X180, 8'd8},  {16'd100, CWD_IDLE, 8'd9},
        {16'd110, CWD_X180, 8'd10}, {16'd120, CWD_IDLE, 8'd11},
        {16'd130, CWD_X180, 8'd12}, {16'd140, CWD_IDLE, 8'd13},
        {16'd150, CWD_X180, 8'd14}, {16'd160, CWD_IDLE, 8'd15},
        {16'd170, CWD_X180, 8'd16}, {16'd180, CWD_IDLE, 8'd17},
        {16'd190, CWD_X180, 8'd18}, {16'd200, CWD_IDLE, 8'd19}
    };

    function automatic int default_len(input int seq);
        if (seq == int'(SELCNT_INIT)) return INIT_LEN;
        if (seq == int'(SELCNT_MEAS)) return MEAS_LEN;
        if (seq == int'(SELCNT_RESM)) return RESM_LEN;
        return 0;
    endfunction

    function automatic entry_t default_entry(input int seq, input int idx);
        entry_t e;
        e = '0;
        if (seq == int'(SELCNT_INIT) && idx < INIT_LEN) e = INIT_PROG[idx];
        if (seq == int'(SELCNT_MEAS) && idx < MEAS_LEN) e = MEAS_PROG[idx];
        if (seq == int'(SELCNT_RESM) && idx < RESM_LEN) e = RESM_PROG[idx];
        return e;
    endfunction

endpackage

// File: rtl/psu_seqptr.sv
// Per-sequence length register and circular read pointer with clear, advance
// and clamping of the pointer when the sequence is shortened below it.
module psu_seqptr #(
    parameter int LEN_BW  = 6,
    parameter int RST_LEN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    input  logic              len_we,
    input  logic [LEN_BW-1:0] len_data,
    output logic [LEN_BW-1:0] len_q,
    output logic [LEN_BW-1:0] ptr_q,
    output logic              last
);

    localparam logic [LEN_BW-1:0] ONE = LEN_BW'(1);

    logic [LEN_BW-1:0] len_d;
    logic [LEN_BW-1:0] ptr_d;

    assign last = (len_q != '0) && (ptr_q == len_q - ONE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        len_d = len_q;
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (adv && len_q != '0) begin
            ptr_d = last ? '0 : ptr_q + ONE;
        end
        // Shrinking the sequence must never leave the pointer outside it, even mid-advance.
        if (len_we) begin
            len_d = len_data;
            if (ptr_q >= len_data || ptr_d >= len_data) ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= LEN_BW'(RST_LEN);
            ptr_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            len_q <= len_d;
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/psu_seqmem.sv
// Runtime-programmable multi-sequence codeword store for the PSU issue stage:
// entry array with write port, per-sequence pointers, combinational read mux, sticky err.
module psu_seqmem
    import psu_pkg::*;
#(
    parameter int NUM_SEQ = 4,
    parameter int MAX_LEN = 32,
    parameter int TIME_BW = PSU_TIME_BW,
    parameter int CWD_BW  = PSU_CWD_BW,
    parameter int SEL_BW  = $clog2(NUM_SEQ),
    parameter int LEN_BW  = $clog2(MAX_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEL_BW-1:0]           sel_cwdNtime,
    input  logic                        next_id,
    input  logic                        ptr_clr,
    input  logic                        wr_en,
    input  logic [SEL_BW-1:0]           wr_sel,
    input  logic [LEN_BW-1:0]           wr_addr,
    input  logic [TIME_BW+2*CWD_BW-1:0] wr_data,
    input  logic                        len_wr_en,
    input  logic [SEL_BW-1:0]           len_sel,
    input  logic [LEN_BW-1:0]           len_data,
    output logic [TIME_BW-1:0]          timing,
    output logic [CWD_BW-1:0]           cwd,
    output logic [CWD_BW-1:0]           cwdsp,
    output logic [LEN_BW-1:0]           id_len,
    output logic [LEN_BW-1:0]           id_ptr,
    output logic                        last,
    output logic                        err
);

    localparam int ENTRY_BW = TIME_BW + 2 * CWD_BW;
    localparam int ADDR_BW  = $clog2(MAX_LEN);

    logic [ENTRY_BW-1:0] mem_q [NUM_SEQ][MAX_LEN];
    logic [ENTRY_BW-1:0] mem_d [NUM_SEQ][MAX_LEN];
    logic                err_q, err_d;
    logic                sel_ok, wr_ok, len_ok;

    logic [LEN_BW-1:0]   seq_len  [NUM_SEQ];
    logic [LEN_BW-1:0]   seq_ptr  [NUM_SEQ];
    logic                seq_last [NUM_SEQ];
    logic [ENTRY_BW-1:0] rd_data;

    always_comb begin
        sel_ok = int'(sel_cwdNtime) < NUM_SEQ;
        wr_ok  = (int'(wr_sel) < NUM_SEQ) && (int'(wr_addr) < MAX_LEN);
        len_ok = (int'(len_sel) < NUM_SEQ) && (int'(len_data) <= MAX_LEN);
        mem_d  = mem_q;
        if (wr_en && wr_ok) mem_d[wr_sel][wr_addr[ADDR_BW-1:0]] = wr_data;
        err_d = err_q | (wr_en && !wr_ok) | (len_wr_en && !len_ok)
              | ((next_id || ptr_clr) && !sel_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the entry array is reset deliberately: reset must reload the default programs.
            for (int s = 0; s < NUM_SEQ; s++) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    mem_q[s][i] <= ENTRY_BW'(default_entry(s, i));
                end
            end
            err_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            err_q <= err_d;
        end
    end

    for (genvar s = 0; s < NUM_SEQ; s++) begin : g_seq
        logic hit;
        assign hit = sel_ok && (int'(sel_cwdNtime) == s);

        psu_seqptr #(
            .LEN_BW  (LEN_BW),
            .RST_LEN (default_len(s))
        ) u_ptr (
            .clk      (clk),
            .rst      (rst),
            .clr      (hit && ptr_clr),
            .adv      (hit && next_id),
            .len_we   (len_wr_en && len_ok && (int'(len_sel) == s)),
            .len_data (len_data),
            .len_q    (seq_len[s]),
            .ptr_q    (seq_ptr[s]),
            .last     (seq_last[s])
        );
    end

    // An empty or out-of-range sequence reads as all zeros.
    always_comb begin
        rd_data = '0;
        id_len  = '0;
        id_ptr  = '0;
        last    = 1'b0;
        if (sel_ok && seq_len[sel_cwdNtime] != '0) begin
            rd_data = mem_q[sel_cwdNtime][seq_ptr[sel_cwdNtime][ADDR_BW-1:0]];
            id_len  = seq_len[sel_cwdNtime];
            id_ptr  = seq_ptr[sel_cwdNtime];
            last    = seq_last[sel_cwdNtime];
        end
    end

    assign {timing, cwd, cwdsp} = rd_data;
    assign err = err_q;

endmodule

// File: tb/tb_psu_seqmem.sv
// Directed bench for psu_seqmem: table-driven read sequence plus hand-written
// sequences for reset defaults, length shrink, write-through timing and err.
module tb_psu_seqmem;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic        next_id, ptr_clr, wr_en, len_wr_en;
    logic [1:0]  wr_sel, len_sel;
    logic [5:0]  wr_addr, len_data;
    logic [31:0] wr_data;
    logic [15:0] timing;
    logic [7:0]  cwd, cwdsp;
    logic [5:0]  id_len, id_ptr;
    logic        last, err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        nx;
        logic        cl;
        logic [31:0] e_data;
        int          e_ptr;
        logic        e_last;
    } vec_t;

    vec_t vt [9];

    localparam logic [31:0] ENT_A = 32'h0011_AA01;
    localparam logic [31:0] ENT_B = 32'h0022_BB02;
    localparam logic [31:0] ENT_C = 32'h0033_CC03;
    localparam logic [31:0] ENT_D = 32'h0044_DD04;

    localparam logic [31:0] INIT0 = 32'h0004_0100;
    localparam logic [31:0] INIT2 = 32'h0008_0300;
    localparam logic [31:0] MEAS0 = 32'h0032_1000;

    psu_seqmem dut (
        .clk          (clk),
        .rst          (rst),
        .sel_cwdNtime (sel),
        .next_id      (next_id),
        .ptr_clr      (ptr_clr),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .len_wr_en    (len_wr_en),
        .len_sel      (len_sel),
        .len_data     (len_data),
        .timing       (timing),
        .cwd          (cwd),
        .cwdsp        (cwdsp),
        .id_len       (id_len),
        .id_ptr       (id_ptr),
        .last         (last),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] resm_exp(input int k);
        logic [15:0] t;
        logic [7:0]  c;
        logic [7:0]  s;
        t = 16'(10 * (k + 1));
        c = (k % 2 == 0) ? 8'h03 : 8'h00;
        s = 8'(k);
        return {t, c, s};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_view(input string name, input logic [31:0] d, input int len,
                              input int ptr, input logic l);
        #1;
        check({name, " data"}, {timing, cwd, cwdsp}, d);
        check({name, " id_len"}, 32'(id_len), 32'(len));
        check({name, " id_ptr"}, 32'(id_ptr), 32'(ptr));
        check({name, " last"}, 32'(last), 32'(l));
    endtask

    task automatic pulse_next(input int n);
        repeat (n) begin
            next_id = 1'b1;
            tick();
            next_id = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; sel = 2'd0; next_id = 1'b0; ptr_clr = 1'b0;
        wr_en = 1'b0; wr_sel = 2'd0; wr_addr = '0; wr_data = '0;
        len_wr_en = 1'b0; len_sel = 2'd0; len_data = '0;

        vt[0] = '{1'b1, 1'b0, ENT_A, 0, 1'b0};
        vt[1] = '{1'b1, 1'b0, ENT_B, 1, 1'b0};
        vt[2] = '{1'b1, 1'b0, ENT_C, 2, 1'b0};
        vt[3] = '{1'b1, 1'b0, ENT_D, 3, 1'b1};
        vt[4] = '{1'b1, 1'b0, ENT_A, 0, 1'b0};
        vt[5] = '{1'b1, 1'b0, ENT_B, 1, 1'b0};
        vt[6] = '{1'b0, 1'b1, ENT_C, 2, 1'b0};
        vt[7] = '{1'b1, 1'b0, ENT_A, 0, 1'b0};
        vt[8] = '{1'b0, 1'b0, ENT_B, 1, 1'b0};

        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_view("rst seq0", INIT0, 3, 0, 1'b0);
        check("rst err", 32'(err), 32'd0);
        sel = 2'd1;
        check_view("rst seq1", MEAS0, 2, 0, 1'b0);
        sel = 2'd3;
        check_view("rst seq3 empty", 32'd0, 0, 0, 1'b0);

        // RESM walk with wrap on the 20th pulse
        sel = 2'd2;
        for (int k = 0; k < 20; k++) begin
            check_view($sformatf("resm[%0d]", k), resm_exp(k), 20, k, k == 19);
            pulse_next(1);
        end
        check_view("resm wrap", resm_exp(0), 20, 0, 1'b0);

        // Program seq 3 and walk it from the vector table
        len_wr_en = 1'b1; len_sel = 2'd3; len_data = 6'd4;
        tick();
        len_wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_sel = 2'd3; wr_addr = 6'(i);
            case (i)
                0: wr_data = ENT_A;
                1: wr_data = ENT_B;
                2: wr_data = ENT_C;
                default: wr_data = ENT_D;
            endcase
            tick();
        end
        wr_en = 1'b0;
        sel = 2'd3;
        for (int i = 0; i < 9; i++) begin
            check_view($sformatf("vec%0d", i), vt[i].e_data, 4, vt[i].e_ptr, vt[i].e_last);
            if (vt[i].nx || vt[i].cl) begin
                next_id = vt[i].nx; ptr_clr = vt[i].cl;
                tick();
                next_id = 1'b0; ptr_clr = 1'b0;
            end
        end

        // Shrink seq 2 below its pointer while advancing
        sel = 2'd2;
        pulse_next(10);
        check_view("resm ptr10", resm_exp(10), 20, 10, 1'b0);
        len_wr_en = 1'b1; len_sel = 2'd2; len_data = 6'd8; next_id = 1'b1;
        tick();
        len_wr_en = 1'b0; next_id = 1'b0;
        check_view("shrink", resm_exp(0), 8, 0, 1'b0);
        pulse_next(7);
        check_view("shrunk last", resm_exp(7), 8, 7, 1'b1);
        pulse_next(1);
        check_view("shrunk wrap", resm_exp(0), 8, 0, 1'b0);
        sel = 2'd3;
        check_view("seq3 held", ENT_B, 4, 1, 1'b0);

        // Length of exactly MAX_LEN is legal
        sel = 2'd2;
        len_wr_en = 1'b1; len_sel = 2'd2; len_data = 6'd32;
        tick();
        len_wr_en = 1'b0;
        check_view("len max", resm_exp(0), 32, 0, 1'b0);
        check("len max err", 32'(err), 32'd0);
        pulse_next(7);
        check_view("seq2 ptr7", resm_exp(7), 32, 7, 1'b0);

        // Write to the entry being read
        sel = 2'd1;
        check_view("seq1 before wr", MEAS0, 2, 0, 1'b0);
        wr_en = 1'b1; wr_sel = 2'd1; wr_addr = 6'd0; wr_data = 32'h1234_5678;
        check_view("wr cycle old", MEAS0, 2, 0, 1'b0);
        tick();
        wr_en = 1'b0;
        check_view("wr next new", 32'h1234_5678, 2, 0, 1'b0);

        // ptr_clr beats next_id; illegal accesses set sticky err
        sel = 2'd0;
        pulse_next(2);
        check_view("init ptr2", INIT2, 3, 2, 1'b1);
        next_id = 1'b1; ptr_clr = 1'b1;
        tick();
        next_id = 1'b0; ptr_clr = 1'b0;
        check_view("clr wins", INIT0, 3, 0, 1'b0);
        check("err before bad wr", 32'(err), 32'd0);
        wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 6'd32; wr_data = 32'hFFFF_FFFF;
        tick();
        wr_en = 1'b0;
        check("err after bad wr", 32'(err), 32'd1);
        check_view("bad wr no change", INIT0, 3, 0, 1'b0);
        len_wr_en = 1'b1; len_sel = 2'd0; len_data = 6'd33;
        tick();
        len_wr_en = 1'b0;
        check_view("bad len ignored", INIT0, 3, 0, 1'b0);
        repeat (3) tick();
        check("err sticky", 32'(err), 32'd1);
        sel = 2'd2;
        check_view("seq2 pre-rst", resm_exp(7), 32, 7, 1'b0);

        // Mid-operation reset with a write in flight
        rst = 1'b1; wr_en = 1'b1; wr_sel = 2'd1; wr_addr = 6'd0; wr_data = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        check_view("post-rst seq2", resm_exp(0), 20, 0, 1'b0);
        check("post-rst err", 32'(err), 32'd0);
        sel = 2'd1;
        check_view("post-rst seq1", MEAS0, 2, 0, 1'b0);
        sel = 2'd0;
        check_view("post-rst seq0", INIT0, 3, 0, 1'b0);
        sel = 2'd3;
        check_view("post-rst seq3", 32'd0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
